// File: rtl/csr_trap_ctrl.sv
// Sequencer between execute and the machine CSR unit: one system op at a time,
// interrupts sampled at accept, CSR faults retried as illegal-instruction traps.
// Ports: clk/reset; req_* (valid/ready request in), irq_* (level interrupts),
// csr_* (op/addr/wdata out, rdata/fault in), resp_* (valid/ready response out).
module csr_trap_ctrl #(
  parameter logic [2:0] IDLE_OP = 3'b010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_kind,
  input  logic [2:0]  req_funct3,
  input  logic [11:0] req_csr,
  input  logic [31:0] req_rs1,
  input  logic [4:0]  req_uimm,
  input  logic [31:0] req_pc,
  input  logic        irq_ext,
  input  logic        irq_sw,
  input  logic        irq_allow,
  output logic [2:0]  csr_op,
  output logic [11:0] csr_addr_exc,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  input  logic        csr_fault,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_retire,
  output logic        resp_redirect,
  output logic [31:0] resp_target
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [2:0]  op_q;
  logic [11:0] ae_q;
  logic [31:0] wd_q;
  logic [31:0] pc_q;
  logic        csr_q;
  logic        mret_q;
  logic [31:0] rdata_q;
  logic [31:0] target_q;
  logic        retire_q;
  logic        redirect_q;

  logic        accept;
  logic        retry;
  logic        irq;
  logic        f3_ok;
  logic [2:0]  d_op;
  logic [11:0] d_ae;
  logic [31:0] d_wd;
  logic        d_csr;
  logic        d_mret;

  assign req_ready = (state == IDLE) & ~reset;
  assign accept    = req_valid & req_ready;
  // only a real CSR access may fault; the trap reissue clears csr_q
  assign retry     = (state == WAIT) & csr_q & csr_fault;

  always_comb begin
    irq    = irq_allow & (irq_ext | irq_sw);
    f3_ok  = req_funct3[1:0] != 2'b00;
    d_op   = 3'b000;
    d_ae   = 12'd2;
    d_wd   = req_pc;
    d_csr  = 1'b0;
    d_mret = 1'b0;
    unique case (1'b1)
      irq: begin
        d_ae = {7'b0, 1'b1, irq_ext ? 4'd11 : 4'd3};
      end
      ~irq & (req_kind == 3'b000) & f3_ok: begin
        d_op  = {1'b1, req_funct3[1:0]};
        d_ae  = req_csr;
        d_wd  = req_funct3[2] ? {27'b0, req_uimm} : req_rs1;
        d_csr = 1'b1;
      end
      ~irq & (req_kind == 3'b001): begin
        d_op   = 3'b001;
        d_ae   = 12'd0;
        d_wd   = 32'd0;
        d_mret = 1'b1;
      end
      ~irq & (req_kind == 3'b010): d_ae = 12'd11;
      ~irq & (req_kind == 3'b011): d_ae = 12'd3;
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (accept) state_nx = ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT:  state_nx = retry ? ISSUE : RESP;
      RESP:  if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= 3'b000;
      ae_q       <= 12'd0;
      wd_q       <= 32'd0;
      pc_q       <= 32'd0;
      csr_q      <= 1'b0;
      mret_q     <= 1'b0;
      rdata_q    <= 32'd0;
      target_q   <= 32'd0;
      retire_q   <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= d_op;
        ae_q   <= d_ae;
        wd_q   <= d_wd;
        pc_q   <= req_pc;
        csr_q  <= d_csr;
        mret_q <= d_mret;
      end
      if (retry) begin
        op_q  <= 3'b000;
        ae_q  <= 12'd2;
        wd_q  <= pc_q;
        csr_q <= 1'b0;
      end
      if ((state == WAIT) && !retry) begin
        rdata_q    <= csr_q ? csr_rdata : 32'd0;
        retire_q   <= csr_q | mret_q;
        redirect_q <= ~csr_q;
        target_q   <= csr_q ? 32'd0 : csr_rdata;
      end
    end
  end

  // the CSR unit sees a command only in ISSUE
  assign csr_op       = (state == ISSUE) ? op_q : IDLE_OP;
  assign csr_addr_exc = (state == ISSUE) ? ae_q : 12'd0;
  assign csr_wdata    = (state == ISSUE) ? wd_q : 32'd0;

  assign resp_valid    = state == RESP;
  assign resp_rdata    = resp_valid ? rdata_q : 32'd0;
  assign resp_retire   = resp_valid & retire_q;
  assign resp_redirect = resp_valid & redirect_q;
  assign resp_target   = resp_valid ? target_q : 32'd0;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: CSR-unit stand-in, per-cycle reference model,
// directed literal cases and randomized requests.
module tb_csr_trap_ctrl;

  localparam logic [2:0] IDLE_OP = 3'b010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_kind = '0;
  logic [2:0]  req_funct3 = '0;
  logic [11:0] req_csr = '0;
  logic [31:0] req_rs1 = '0;
  logic [4:0]  req_uimm = '0;
  logic [31:0] req_pc = '0;
  logic        irq_ext = 1'b0;
  logic        irq_sw = 1'b0;
  logic        irq_allow = 1'b0;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr_exc;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata = '0;
  logic        csr_fault = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_retire;
  logic        resp_redirect;
  logic [31:0] resp_target;

  csr_trap_ctrl #(.IDLE_OP(IDLE_OP)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_funct3(req_funct3),
    .req_csr(req_csr), .req_rs1(req_rs1),
    .req_uimm(req_uimm), .req_pc(req_pc),
    .irq_ext(irq_ext), .irq_sw(irq_sw), .irq_allow(irq_allow),
    .csr_op(csr_op), .csr_addr_exc(csr_addr_exc),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .csr_fault(csr_fault),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_retire(resp_retire),
    .resp_redirect(resp_redirect), .resp_target(resp_target)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h",
               nm, cyc, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] mstatus;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
  } cs_t;

  // Machine CSR file behaviour, shared by the CSR-unit stand-in and the model.
  function automatic void csr_do(input cs_t s, input logic [2:0] op,
                                 input logic [11:0] a, input logic [31:0] w,
                                 output cs_t n, output logic [31:0] old,
                                 output logic flt);
    logic [31:0] nv;
    logic known, wr;
    n = s; old = 0; flt = 0; known = 1;
    if (op == 3'b000) begin
      n.mepc = w; old = s.mtvec;
    end else if (op == 3'b001) begin
      old = s.mepc;
    end else begin
      case (a)
        12'h300: old = s.mstatus;
        12'h305: old = s.mtvec;
        12'h340: old = s.mscratch;
        12'h341: old = s.mepc;
        12'hF14: old = 0;
        default: known = 0;
      endcase
      case (op[1:0])
        2'b01:   nv = w;
        2'b10:   nv = old | w;
        default: nv = old & ~w;
      endcase
      wr = (op[1:0] == 2'b01) || (w != 0);
      if (!known) flt = 1;
      else if (wr) begin
        if (a == 12'hF14 || (a == 12'h341 && nv[0])) flt = 1;
        else case (a)
          12'h300: n.mstatus = nv;
          12'h305: n.mtvec = nv;
          12'h340: n.mscratch = nv;
          12'h341: n.mepc = nv;
          default: ;
        endcase
      end
    end
  endfunction

  cs_t env = {32'h1800, 32'h10, 32'h0, 32'h0};

  always @(posedge clk) begin : csr_unit
    cs_t nx;
    logic [31:0] o;
    logic f;
    if (csr_op != IDLE_OP) begin
      csr_do(env, csr_op, csr_addr_exc, csr_wdata, nx, o, f);
      env <= nx;
      csr_rdata <= o;
      csr_fault <= f;
    end else begin
      csr_fault <= 1'b0;
    end
  end

  // reference model state
  cs_t         rs;
  bit          busy = 0;
  bit          sync_n = 1;
  int          t_acc = 0;
  int          m_lat = 3;
  int          n_iss = 1;
  logic [2:0]  e_op [2];
  logic [11:0] e_ae [2];
  logic [31:0] e_wd [2];
  bit          e_aw [2];
  logic        e_ret, e_red;
  logic [31:0] e_rd, e_tg;

  task automatic trap(input logic [11:0] code);
    e_op[0] = 3'b000; e_ae[0] = code; e_wd[0] = req_pc;
    m_lat = 3; e_ret = 0; e_red = 1; e_rd = 0;
    e_tg = rs.mtvec; rs.mepc = req_pc;
  endtask

  task automatic predict();
    cs_t n;
    logic [31:0] old, w;
    logic flt;
    logic [2:0] op;
    n_iss = 1; e_aw[0] = 1; e_aw[1] = 1; e_rd = 0;
    if (irq_allow && (irq_ext || irq_sw)) begin
      trap(irq_ext ? 12'h01B : 12'h013);
    end else if (req_kind == 3'd0 && req_funct3[1:0] != 2'b00) begin
      op = {1'b1, req_funct3[1:0]};
      w = req_funct3[2] ? {27'b0, req_uimm} : req_rs1;
      e_op[0] = op; e_ae[0] = req_csr; e_wd[0] = w;
      csr_do(rs, op, req_csr, w, n, old, flt);
      if (!flt) begin
        rs = n; m_lat = 3; e_ret = 1; e_red = 0; e_rd = old; e_tg = 0;
      end else begin
        n_iss = 2;
        e_op[1] = 3'b000; e_ae[1] = 12'd2; e_wd[1] = req_pc;
        m_lat = 5; e_ret = 0; e_red = 1;
        e_tg = rs.mtvec; rs.mepc = req_pc;
      end
    end else if (req_kind == 3'd1) begin
      e_op[0] = 3'b001; e_aw[0] = 0;
      m_lat = 3; e_ret = 1; e_red = 1; e_tg = rs.mepc;
    end else if (req_kind == 3'd2) trap(12'd11);
    else if (req_kind == 3'd3) trap(12'd3);
    else trap(12'd2);
  endtask

  always @(negedge clk) begin : compare
    int k, j;
    logic [2:0] xo;
    bit rv;
    if (reset) begin
      chk("req_ready_in_reset", req_ready, 0);
      busy = 0; sync_n = 1;
    end else begin
      if (sync_n) begin rs = env; sync_n = 0; end
      k = cyc - t_acc;
      j = -1;
      if (busy && k == 1) j = 0;
      if (busy && k == 3 && n_iss == 2) j = 1;
      xo = (j >= 0) ? e_op[j] : IDLE_OP;
      chk("req_ready", req_ready, !busy);
      chk("csr_op", csr_op, xo);
      if (j >= 0 && e_aw[j]) begin
        chk("csr_addr_exc", csr_addr_exc, e_ae[j]);
        chk("csr_wdata", csr_wdata, e_wd[j]);
      end
      rv = busy && k >= m_lat;
      chk("resp_valid", resp_valid, rv);
      if (rv) begin
        chk("resp_retire", resp_retire, e_ret);
        chk("resp_redirect", resp_redirect, e_red);
        chk("resp_rdata", resp_rdata, e_rd);
        if (e_red) chk("resp_target", resp_target, e_tg);
      end
      if (rv && resp_ready) busy = 0;
      else if (!busy && req_valid) begin
        busy = 1; t_acc = cyc; predict();
      end
    end
  end

  // captured by the driver for literal checks
  logic [2:0]  f_op, l_op;
  logic [11:0] f_ae, l_ae;
  logic [31:0] f_wd, l_wd;
  logic [31:0] r_rd, r_tg;
  logic        r_ret, r_red;
  int          r_lat;

  task automatic send(input logic [2:0] kind, input logic [2:0] f3,
                      input logic [11:0] csr, input logic [31:0] rs1,
                      input logic [4:0] uimm, input logic [31:0] pc,
                      input logic ext, input logic sw, input logic allow,
                      input int low);
    int n;
    bit seen;
    req_kind = kind; req_funct3 = f3; req_csr = csr;
    req_rs1 = rs1; req_uimm = uimm; req_pc = pc;
    irq_ext = ext; irq_sw = sw; irq_allow = allow;
    req_valid = 1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("accept_timeout", 0, 1);
      req_valid = 0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 0; irq_ext = $urandom_range(0, 1); irq_sw = 0;
    r_lat = 1; seen = 0;
    f_op = IDLE_OP; f_ae = 0; f_wd = 0;
    l_op = IDLE_OP; l_ae = 0; l_wd = 0;
    forever begin
      @(negedge clk);
      if (csr_op != IDLE_OP) begin
        if (!seen) begin f_op = csr_op; f_ae = csr_addr_exc; f_wd = csr_wdata; end
        l_op = csr_op; l_ae = csr_addr_exc; l_wd = csr_wdata; seen = 1;
      end
      if (resp_valid || r_lat >= 20) break;
      @(posedge clk); r_lat++;
    end
    if (!resp_valid) begin
      chk("resp_timeout", 0, 1);
      return;
    end
    r_rd = resp_rdata; r_tg = resp_target;
    r_ret = resp_retire; r_red = resp_redirect;
    repeat (low - 1) @(posedge clk);
    @(posedge clk); #1 resp_ready = 1;
    @(posedge clk); #1 resp_ready = 0;
  endtask

  logic [11:0] csrs [6] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'hF14, 12'h7C0};

  initial begin
    logic [31:0] v;
    int g;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_csr_op", csr_op, IDLE_OP);
    chk("rst_addr_exc", csr_addr_exc, 0);
    chk("rst_wdata", csr_wdata, 0);
    chk("rst_retire", resp_retire, 0);
    @(posedge clk); #1;

    send(3'd0, 3'b001, 12'h300, 32'h8, 5'd0, 32'h200, 0, 0, 0, 1);
    chk("rw_op", f_op, 3'b101);
    chk("rw_wdata", f_wd, 32'h8);
    chk("rw_lat", r_lat, 3);
    chk("rw_retire", r_ret, 1);
    chk("rw_rdata", r_rd, 32'h1800);

    send(3'd0, 3'b010, 12'h341, 32'h0, 5'd0, 32'h40, 0, 0, 0, 1);
    chk("rs0_retire", r_ret, 1);
    chk("rs0_redirect", r_red, 0);
    chk("rs0_lat", r_lat, 3);

    send(3'd0, 3'b010, 12'h341, 32'h1, 5'd0, 32'h44, 0, 0, 0, 1);
    chk("flt_lat", r_lat, 5);
    chk("flt_addr_exc", l_ae, 12'd2);
    chk("flt_wdata", l_wd, 32'h44);
    chk("flt_retire", r_ret, 0);
    chk("flt_target", r_tg, 32'h10);

    send(3'd2, 3'b000, 12'h0, 32'h0, 5'd0, 32'h100, 0, 0, 0, 4);
    chk("ecall_op", f_op, 3'b000);
    chk("ecall_addr_exc", f_ae, 12'h00B);
    chk("ecall_wdata", f_wd, 32'h100);
    chk("ecall_redirect", r_red, 1);
    chk("ecall_target", r_tg, 32'h10);

    send(3'd1, 3'b000, 12'h0, 32'h0, 5'd0, 32'h10, 0, 0, 0, 1);
    chk("mret_op", f_op, 3'b001);
    chk("mret_target", r_tg, 32'h100);
    chk("mret_retire", r_ret, 1);

    send(3'd0, 3'b010, 12'h340, 32'h0, 5'd0, 32'h300, 1, 1, 1, 1);
    chk("irq_addr_exc", f_ae, 12'h01B);
    chk("irq_wdata", f_wd, 32'h300);
    chk("irq_retire", r_ret, 0);
    chk("irq_target", r_tg, 32'h10);

    send(3'd0, 3'b001, 12'h340, 32'h55, 5'd0, 32'h304, 1, 1, 0, 1);
    chk("masked_op", f_op, 3'b101);
    chk("masked_retire", r_ret, 1);
    chk("masked_rdata", r_rd, 32'h0);

    send(3'd0, 3'b101, 12'h340, 32'hFFFF, 5'd5, 32'h308, 0, 0, 0, 1);
    chk("rwi_wdata", f_wd, 32'h5);
    chk("rwi_rdata", r_rd, 32'h55);

    send(3'd6, 3'b000, 12'h0, 32'h0, 5'd0, 32'h30C, 0, 0, 0, 1);
    chk("ill_addr_exc", f_ae, 12'd2);
    chk("ill_redirect", r_red, 1);

    req_kind = 3'd0; req_funct3 = 3'b010; req_csr = 12'h300;
    req_rs1 = 0; req_valid = 1;
    @(posedge clk); #1 req_valid = 0;
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("rstwait_resp_valid", resp_valid, 0);
    chk("rstwait_csr_op", csr_op, IDLE_OP);
    chk("rstwait_ready", req_ready, 1);
    repeat (5) @(posedge clk);
    #1;

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: v = 0;
        1: v = 1;
        2: v = $urandom;
        default: v = 32'h100;
      endcase
      send(($urandom_range(0, 9) < 5) ? 3'd0 : 3'($urandom_range(1, 7)),
           3'($urandom_range(0, 7)), csrs[$urandom_range(0, 5)], v,
           5'($urandom), {$urandom_range(0, 32'hFFFF), 2'b00},
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(1, 4));
      g = $urandom_range(0, 2);
      if (g != 0) begin repeat (g) @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
